// File: rtl/mat_row_accumulator.sv
// rtl/mat_row_accumulator.sv - row-by-row matrix RAM reader producing per-row sums on a valid/ready port
module mat_row_accumulator #(
    parameter int DW = 8,
    parameter int m  = 8,
    parameter int n  = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            abort,
    output logic                            busy,
    output logic                            done,
    output logic                            ramEN,
    output logic                            readEN,
    output logic [m+n-1:0]                  addr,
    input  logic [2*DW-1:0]                 mem_data,
    output logic                            sumValid,
    input  logic                            sumReady,
    output logic [2*DW+$clog2(n+1)-1:0]     sumData,
    output logic [m-1:0]                    sumRow
);

    localparam int SW = 2*DW + $clog2(n+1);
    localparam int AW = m + n;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [m-1:0]    row_q, row_d;
    logic [n-1:0]    col_q, col_d;
    logic [SW-1:0]   acc_q, acc_d;
    logic            rdv_q, rdv_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            done_q, done_d;
    logic [AW-1:0]   issue_addr;

    // Address of the word being requested this cycle (meaningful only in READ).
    assign issue_addr = AW'(row_q) * AW'(n) + AW'(col_q);

    // Next-state logic: sweep sequencing, accumulation of returned data, abort override.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        acc_d   = acc_q;
        rdv_d   = (state_q == S_READ);
        addr_d  = addr_q;
        done_d  = 1'b0;

        // Data from the read issued last cycle arrives now.
        if (rdv_q) begin
            acc_d = acc_q + SW'(mem_data);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READ;
                    row_d   = '0;
                    col_d   = '0;
                    acc_d   = '0;
                end
            end
            S_READ: begin
                addr_d = issue_addr;
                if (int'(col_q) == n - 1) begin
                    col_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            S_DRAIN: begin
                state_d = S_OUT;
            end
            S_OUT: begin
                if (sumReady) begin
                    if (int'(row_q) == m - 1) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        row_d   = row_q + 1'b1;
                        acc_d   = '0;
                        state_d = S_READ;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort beats everything, including a handshake in the same cycle.
        if (abort) begin
            state_d = S_IDLE;
            row_d   = '0;
            col_d   = '0;
            acc_d   = '0;
            rdv_d   = 1'b0;
            done_d  = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            acc_q   <= '0;
            rdv_q   <= 1'b0;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            acc_q   <= acc_d;
            rdv_q   <= rdv_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign ramEN    = (state_q == S_READ);
    assign readEN   = (state_q == S_READ);
    assign addr     = (state_q == S_READ) ? issue_addr : addr_q;
    assign sumValid = (state_q == S_OUT);
    assign sumData  = acc_q;
    assign sumRow   = row_q;
    assign done     = done_q;

endmodule

// File: tb/tb_mat_row_accumulator.sv
// tb/tb_mat_row_accumulator.sv - self-checking bench for mat_row_accumulator
module tb_mat_row_accumulator;

    typedef struct {
        int          row;
        logic [19:0] sum;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic        ramEN;
    logic        readEN;
    logic [15:0] addr;
    logic [15:0] mem_data;
    logic        sumValid;
    logic        sumReady;
    logic [19:0] sumData;
    logic [7:0]  sumRow;

    logic [15:0] mem [0:63];
    vec_t        tbl [0:15];
    int          pass_cnt = 0;
    int          total_cnt = 0;

    mat_row_accumulator #(.DW(8), .m(8), .n(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .ramEN    (ramEN),
        .readEN   (readEN),
        .addr     (addr),
        .mem_data (mem_data),
        .sumValid (sumValid),
        .sumReady (sumReady),
        .sumData  (sumData),
        .sumRow   (sumRow)
    );

    always #5 clk = ~clk;

    // Registered-read RAM model.
    initial mem_data = 16'h0;
    always @(posedge clk) begin
        if (ramEN && readEN) mem_data <= mem[addr[5:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_inc();
        for (int i = 0; i < 64; i++) mem[i] = 16'(i);
    endtask

    task automatic fill_max();
        for (int i = 0; i < 64; i++) mem[i] = 16'hFFFF;
    endtask

    // Full sweep with sumReady held high; sums checked against tbl[base..base+7].
    task automatic run_sweep(input int base, input string tag);
        int idx = 0;
        int edges = 0;
        int done_edge = -1;
        int next_addr = 0;
        int addr_bad = 0;
        start = 1'b1;
        sumReady = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (ramEN) begin
                if (addr != 16'(next_addr)) addr_bad++;
                next_addr++;
            end
            if (sumValid && idx < 8) begin
                check({tag, " sum"}, 32'(sumData), 32'(tbl[base+idx].sum));
                check({tag, " row"}, 32'(sumRow), 32'(tbl[base+idx].row));
                idx++;
            end
            if (done) begin
                done_edge = edges;
                break;
            end
            step();
            edges++;
        end
        check({tag, " done_cycle"}, 32'(done_edge), 32'd80);
        check({tag, " addr_order_errors"}, 32'(addr_bad), 32'd0);
        check({tag, " reads_issued"}, 32'(next_addr), 32'd64);
        check({tag, " rows_seen"}, 32'(idx), 32'd8);
        step();
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
        check({tag, " idle_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int found;
        int hold_bad;

        tbl[0]  = '{0, 20'd28};
        tbl[1]  = '{1, 20'd92};
        tbl[2]  = '{2, 20'd156};
        tbl[3]  = '{3, 20'd220};
        tbl[4]  = '{4, 20'd284};
        tbl[5]  = '{5, 20'd348};
        tbl[6]  = '{6, 20'd412};
        tbl[7]  = '{7, 20'd476};
        tbl[8]  = '{0, 20'd524280};
        tbl[9]  = '{1, 20'd524280};
        tbl[10] = '{2, 20'd524280};
        tbl[11] = '{3, 20'd524280};
        tbl[12] = '{4, 20'd524280};
        tbl[13] = '{5, 20'd524280};
        tbl[14] = '{6, 20'd524280};
        tbl[15] = '{7, 20'd524280};

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        sumReady = 1'b0;
        fill_inc();
        step();
        step();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset ramEN", 32'(ramEN), 32'd0);
        check("reset addr", 32'(addr), 32'd0);
        check("reset sumValid", 32'(sumValid), 32'd0);
        check("reset sumData", 32'(sumData), 32'd0);
        check("reset sumRow", 32'(sumRow), 32'd0);
        rst_n = 1'b1;
        step();

        // T1: reset mid-READ
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("T1 in READ", 32'(ramEN), 32'd1);
        rst_n = 1'b0;
        #1;
        check("T1 busy", 32'(busy), 32'd0);
        check("T1 ramEN", 32'(ramEN), 32'd0);
        check("T1 readEN", 32'(readEN), 32'd0);
        check("T1 addr", 32'(addr), 32'd0);
        check("T1 sumData", 32'(sumData), 32'd0);
        check("T1 sumValid", 32'(sumValid), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("T1 idle after release", 32'(busy), 32'd0);

        // T2: full sweep of incrementing data
        run_sweep(0, "T2");

        // T3: backpressure on row 2
        start = 1'b1;
        sumReady = 1'b1;
        step();
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 100; k++) begin
            if (sumValid && sumRow == 8'd2) begin
                found = 1;
                break;
            end
            step();
        end
        check("T3 reached row2", 32'(found), 32'd1);
        sumReady = 1'b0;
        check("T3 sumData", 32'(sumData), 32'd156);
        hold_bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (!(sumValid && sumData == 20'd156 && sumRow == 8'd2 && !ramEN && !readEN))
                hold_bad++;
        end
        check("T3 hold errors", 32'(hold_bad), 32'd0);
        sumReady = 1'b1;
        step();
        check("T3 row3 ramEN", 32'(ramEN), 32'd1);
        check("T3 row3 addr", 32'(addr), 32'd24);
        check("T3 row3 sumRow", 32'(sumRow), 32'd3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("T3 abort idle", 32'(busy), 32'd0);

        // T4: all-ones data
        fill_max();
        run_sweep(8, "T4");
        fill_inc();

        // T5: start ignored while busy, abort mid-row, restart
        start = 1'b1;
        sumReady = 1'b1;
        step();
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 100; k++) begin
            if (ramEN && sumRow == 8'd1) begin
                found = 1;
                break;
            end
            step();
        end
        check("T5 reached row1", 32'(found), 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("T5 start ignored addr", 32'(addr), 32'd9);
        found = 0;
        for (int k = 0; k < 100; k++) begin
            if (sumValid) begin
                found = 1;
                break;
            end
            step();
        end
        check("T5 row1 sum", 32'(sumData), 32'd92);
        check("T5 row1 row", 32'(sumRow), 32'd1);
        found = 0;
        for (int k = 0; k < 100; k++) begin
            if (ramEN && sumRow == 8'd3) begin
                found = 1;
                break;
            end
            step();
        end
        check("T5 reached row3", 32'(found), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("T5 abort busy", 32'(busy), 32'd0);
        check("T5 abort ramEN", 32'(ramEN), 32'd0);
        check("T5 abort done", 32'(done), 32'd0);
        step();
        check("T5 abort done later", 32'(done), 32'd0);
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("T5 start+abort idle", 32'(busy), 32'd0);
        run_sweep(0, "T5 restart");

        // T6: abort coinciding with the row-7 handshake
        start = 1'b1;
        sumReady = 1'b1;
        step();
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 200; k++) begin
            if (sumValid && sumRow == 8'd7) begin
                found = 1;
                break;
            end
            step();
        end
        check("T6 reached row7", 32'(found), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("T6 done", 32'(done), 32'd0);
        check("T6 busy", 32'(busy), 32'd0);
        check("T6 sumValid", 32'(sumValid), 32'd0);
        step();
        check("T6 done later", 32'(done), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
